// File: rtl/axi_scratchpad_responder.sv
// ============================================================================
// Module   : axi_scratchpad_responder
// Brief    : AXI4 subordinate serving a flop-based scratchpad, one burst at a time
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_scratchpad_responder #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic [5:0]              aw_atop_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int EXT_W = ADDR_WIDTH + 9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [EXT_W-1:0] RANGE_LO = EXT_W'(BASE_ADDR);
  localparam logic [EXT_W-1:0] RANGE_HI = RANGE_LO + EXT_W'(NUM_WORDS * 8) - EXT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;

  state_t                  state;
  logic                    rr_write_first;
  logic [ID_WIDTH-1:0]     cur_id;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [7:0]              cur_len;
  logic [2:0]              cur_size;
  logic [1:0]              cur_burst;
  logic [1:0]              code;
  logic [8:0]              beat;
  logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

  logic                    grant_w, grant_r, mem_we;
  logic [1:0]              aw_code, ar_code;
  logic [ADDR_WIDTH-1:0]   rd_next;

  // End address is formed in the widened domain so a huge start cannot wrap past the top.
  function automatic logic [1:0] access_code(input logic [5:0]            atop,
                                              input logic [1:0]            burst,
                                              input logic [2:0]            size,
                                              input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [7:0]            len);
    logic [EXT_W-1:0] beat_bytes, span, first, last;
    beat_bytes = EXT_W'(1) << size;
    span       = (burst == BURST_FIXED) ? beat_bytes : ((EXT_W'(len) + EXT_W'(1)) << size);
    first      = EXT_W'(addr);
    last       = (first & ~(beat_bytes - EXT_W'(1))) + span - EXT_W'(1);
    if (atop != 6'd0)                                  return RESP_SLVERR;
    else if (burst == BURST_WRAP || burst == 2'b11)    return RESP_SLVERR;
    else if (size > 3'd3)                              return RESP_SLVERR;
    else if (first < RANGE_LO || last > RANGE_HI)      return RESP_DECERR;
    else                                               return RESP_OKAY;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] bytes;
    bytes = ADDR_WIDTH'(1) << size;
    if (burst == BURST_FIXED) return addr;
    return (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[3 +: IDX_W];
  endfunction

  assign aw_code = access_code(aw_atop_i, aw_burst_i, aw_size_i, aw_addr_i, aw_len_i);
  assign ar_code = access_code(6'd0, ar_burst_i, ar_size_i, ar_addr_i, ar_len_i);

  assign grant_w    = (state == S_IDLE) && aw_valid_i && (!ar_valid_i || rr_write_first);
  assign grant_r    = (state == S_IDLE) && ar_valid_i && (!aw_valid_i || !rr_write_first);
  assign aw_ready_o = grant_w && !rst_i;
  assign ar_ready_o = grant_r && !rst_i;
  assign w_ready_o  = (state == S_WRITE);
  assign rd_next    = next_addr(cur_addr, cur_size, cur_burst);

  // Beats past the announced length are absorbed but never stored.
  assign mem_we = (state == S_WRITE) && w_valid_i && (code == RESP_OKAY) &&
                  (beat <= {1'b0, cur_len});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (w_strb_i[b]) mem[word_index(cur_addr)][8*b +: 8] <= w_data_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      rr_write_first <= 1'b1;
      cur_id         <= '0;
      cur_addr       <= '0;
      cur_len        <= '0;
      cur_size       <= '0;
      cur_burst      <= '0;
      code           <= RESP_OKAY;
      beat           <= '0;
      b_valid_o      <= 1'b0;
      b_id_o         <= '0;
      b_resp_o       <= '0;
      r_valid_o      <= 1'b0;
      r_id_o         <= '0;
      r_data_o       <= '0;
      r_resp_o       <= '0;
      r_last_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_w) begin
            cur_id         <= aw_id_i;
            cur_addr       <= aw_addr_i;
            cur_len        <= aw_len_i;
            cur_size       <= aw_size_i;
            cur_burst      <= aw_burst_i;
            code           <= aw_code;
            beat           <= '0;
            rr_write_first <= 1'b0;
            state          <= S_WRITE;
          end else if (grant_r) begin
            cur_id         <= ar_id_i;
            cur_addr       <= ar_addr_i;
            cur_len        <= ar_len_i;
            cur_size       <= ar_size_i;
            cur_burst      <= ar_burst_i;
            code           <= ar_code;
            beat           <= '0;
            rr_write_first <= 1'b1;
            r_valid_o      <= 1'b1;
            r_id_o         <= ar_id_i;
            r_resp_o       <= ar_code;
            r_last_o       <= (ar_len_i == 8'd0);
            r_data_o       <= (ar_code == RESP_OKAY) ? mem[word_index(ar_addr_i)] : '0;
            state          <= S_READ;
          end
        end
        S_WRITE: begin
          if (w_valid_i) begin
            cur_addr <= rd_next;
            if (beat != 9'h1FF) beat <= beat + 9'd1;
            if (w_last_i) begin
              b_valid_o <= 1'b1;
              b_id_o    <= cur_id;
              b_resp_o  <= (beat == {1'b0, cur_len}) ? code : RESP_SLVERR;
              state     <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_READ: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              r_valid_o <= 1'b0;
              state     <= S_IDLE;
            end else begin
              cur_addr <= rd_next;
              beat     <= beat + 9'd1;
              r_last_o <= ((beat + 9'd1) == {1'b0, cur_len});
              r_data_o <= (code == RESP_OKAY) ? mem[word_index(rd_next)] : '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_scratchpad_responder.sv
// ============================================================================
// Module   : tb_axi_scratchpad_responder
// Brief    : Directed self-checking bench for axi_scratchpad_responder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_scratchpad_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        aw_valid_i = 1'b0, aw_ready_o;
  logic [3:0]  aw_id_i = '0;
  logic [63:0] aw_addr_i = '0;
  logic [7:0]  aw_len_i = '0;
  logic [2:0]  aw_size_i = 3'd3;
  logic [1:0]  aw_burst_i = 2'b01;
  logic [5:0]  aw_atop_i = '0;
  logic        w_valid_i = 1'b0, w_ready_o;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        w_last_i = 1'b0;
  logic        b_valid_o, b_ready_i = 1'b1;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 1'b0, ar_ready_o;
  logic [3:0]  ar_id_i = '0;
  logic [63:0] ar_addr_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic [2:0]  ar_size_i = 3'd3;
  logic [1:0]  ar_burst_i = 2'b01;
  logic        r_valid_o, r_ready_i = 1'b1;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;

  int nvec = 0;
  int nerr = 0;

  axi_scratchpad_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i), .aw_atop_i(aw_atop_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking of DUT values) ----------------
  task automatic wait_aw_hs();
    int n = 0;
    #1;
    while (!aw_ready_o && n < 100) begin @(negedge clk_i); #1; n++; end
    if (!aw_ready_o) begin
      nvec++; nerr++;
      $display("FAIL aw_handshake: aw_ready_o=0 after %0d cycles, required 1", n);
    end
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic wait_ar_hs();
    int n = 0;
    #1;
    while (!ar_ready_o && n < 100) begin @(negedge clk_i); #1; n++; end
    if (!ar_ready_o) begin
      nvec++; nerr++;
      $display("FAIL ar_handshake: ar_ready_o=0 after %0d cycles, required 1", n);
    end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = 3'd3;
    aw_burst_i = burst; aw_atop_i = atop; aw_valid_i = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = 3'd3;
    ar_burst_i = burst; ar_valid_i = 1'b1;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_data_i = data; w_strb_i = strb; w_last_i = last; w_valid_i = 1'b1;
    #1;
    while (!w_ready_o && n < 100) begin @(negedge clk_i); #1; n++; end
    if (!w_ready_o) begin
      nvec++; nerr++;
      $display("FAIL w_handshake: w_ready_o=0 after %0d cycles, required 1", n);
    end
    @(posedge clk_i); #1;
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  task automatic get_b(output logic [3:0] id, output logic [1:0] resp, output int waited);
    waited = 0;
    while (!b_valid_o && waited < 100) begin @(negedge clk_i); #1; waited++; end
    if (!b_valid_o) begin
      nvec++; nerr++;
      $display("FAIL b_timeout: b_valid_o=0 after %0d cycles, required 1", waited);
    end
    id = b_id_o; resp = b_resp_o;
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic get_r(output logic [63:0] data, output logic [1:0] resp, output logic last,
                       output logic [3:0] id, output int waited);
    waited = 0;
    r_ready_i = 1'b1;
    while (!r_valid_o && waited < 100) begin @(negedge clk_i); #1; waited++; end
    if (!r_valid_o) begin
      nvec++; nerr++;
      $display("FAIL r_timeout: r_valid_o=0 after %0d cycles, required 1", waited);
    end
    data = r_data_o; resp = r_resp_o; last = r_last_o; id = r_id_o;
    @(posedge clk_i); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    aw_valid_i = 1'b1; ar_valid_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i); #1;
    nvec++; if (aw_ready_o !== 1'b0) begin nerr++; $display("FAIL reset_aw_ready: got %b, expected 0", aw_ready_o); end
    nvec++; if (ar_ready_o !== 1'b0) begin nerr++; $display("FAIL reset_ar_ready: got %b, expected 0", ar_ready_o); end
    nvec++; if ({w_ready_o, b_valid_o, r_valid_o} !== 3'b000) begin nerr++; $display("FAIL reset_valids: got %b, expected 000", {w_ready_o, b_valid_o, r_valid_o}); end
    nvec++; if ({b_id_o, b_resp_o, r_id_o, r_resp_o, r_last_o, r_data_o} !== '0) begin nerr++; $display("FAIL reset_payload: got b_id=%h b_resp=%h r_id=%h r_data=%h, expected all 0", b_id_o, b_resp_o, r_id_o, r_data_o); end
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    set_aw(4'h5, 64'h8000_0010, 8'd0, 2'b01, 6'd0);
    wait_aw_hs();
    send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
    get_b(id, resp, wt);
    nvec++; if (wt !== 0) begin nerr++; $display("FAIL single_b_latency: waited %0d cycles, expected 0", wt); end
    nvec++; if ({id, resp} !== {4'h5, 2'b00}) begin nerr++; $display("FAIL single_b: got id=%h resp=%h, expected id=5 resp=0", id, resp); end
    set_ar(4'h9, 64'h8000_0010, 8'd0, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if (wt !== 0) begin nerr++; $display("FAIL single_r_latency: waited %0d cycles, expected 0", wt); end
    nvec++; if ({d, resp, last, id} !== {64'hDEAD_BEEF_0123_4567, 2'b00, 1'b1, 4'h9}) begin nerr++; $display("FAIL single_r: got data=%h resp=%h last=%b id=%h, expected deadbeef01234567/0/1/9", d, resp, last, id); end
  endtask

  task automatic test_burst();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    logic [63:0] wdat [4];
    logic [7:0]  wstb [4];
    logic [63:0] exp  [4];
    wdat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wstb = '{8'hFF, 8'hFF, 8'h0F, 8'hFF};
    // word 2 still holds the earlier single write in its upper half
    exp  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'hDEAD_BEEF_3333_3333, 64'h4444_4444_4444_4444};
    set_aw(4'h2, 64'h8000_0000, 8'd3, 2'b01, 6'd0);
    wait_aw_hs();
    for (int i = 0; i < 4; i++) send_w(wdat[i], wstb[i], i == 3);
    get_b(id, resp, wt);
    nvec++; if ({id, resp} !== {4'h2, 2'b00}) begin nerr++; $display("FAIL burst_b: got id=%h resp=%h, expected 2/0", id, resp); end
    set_ar(4'h3, 64'h8000_0000, 8'd3, 2'b01);
    wait_ar_hs();
    for (int i = 0; i < 4; i++) begin
      get_r(d, resp, last, id, wt);
      nvec++;
      if ({d, resp, last, id} !== {exp[i], 2'b00, (i == 3), 4'h3} || wt != 0) begin
        nerr++;
        $display("FAIL burst_r%0d: got data=%h resp=%h last=%b id=%h wait=%0d, expected %h/0/%0d/3/0", i, d, resp, last, id, wt, exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    set_aw(4'h7, 64'h8000_0018, 8'd0, 2'b01, 6'h20);
    wait_aw_hs();
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    get_b(id, resp, wt);
    nvec++; if ({id, resp} !== {4'h7, 2'b10}) begin nerr++; $display("FAIL atop_b: got id=%h resp=%h, expected 7/2", id, resp); end
    set_ar(4'h1, 64'h8000_0018, 8'd0, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, resp} !== {64'h4444_4444_4444_4444, 2'b00}) begin nerr++; $display("FAIL atop_mem: got data=%h resp=%h, expected 4444444444444444/0", d, resp); end

    set_ar(4'h4, 64'h7FFF_FFF8, 8'd0, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, resp, last} !== {64'h0, 2'b11, 1'b1}) begin nerr++; $display("FAIL below_base: got data=%h resp=%h last=%b, expected 0/3/1", d, resp, last); end

    set_ar(4'h6, 64'h8000_07F8, 8'd1, 2'b01);
    wait_ar_hs();
    for (int i = 0; i < 2; i++) begin
      get_r(d, resp, last, id, wt);
      nvec++;
      if ({d, resp, last} !== {64'h0, 2'b11, (i == 1)}) begin
        nerr++;
        $display("FAIL past_top%0d: got data=%h resp=%h last=%b, expected 0/3/%0d", i, d, resp, last, (i == 1));
      end
    end

    set_ar(4'h8, 64'h8000_07F8, 8'd0, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, resp, last} !== {64'h0, 2'b00, 1'b1}) begin nerr++; $display("FAIL top_word: got data=%h resp=%h last=%b, expected 0/0/1", d, resp, last); end

    set_ar(4'hA, 64'h8000_0000, 8'd0, 2'b10);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, resp} !== {64'h0, 2'b10}) begin nerr++; $display("FAIL wrap_burst: got data=%h resp=%h, expected 0/2", d, resp); end

    set_aw(4'hB, 64'h8000_0020, 8'd1, 2'b01, 6'd0);
    wait_aw_hs();
    send_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    get_b(id, resp, wt);
    nvec++; if ({id, resp} !== {4'hB, 2'b10}) begin nerr++; $display("FAIL early_last: got id=%h resp=%h, expected b/2", id, resp); end
  endtask

  task automatic test_arbitration();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    apply_reset();
    set_aw(4'h1, 64'h8000_0040, 8'd0, 2'b01, 6'd0);
    set_ar(4'h2, 64'h8000_0040, 8'd0, 2'b01);
    #1;
    nvec++; if ({aw_ready_o, ar_ready_o} !== 2'b10) begin nerr++; $display("FAIL arb_first: got aw_ready,ar_ready=%b, expected 10", {aw_ready_o, ar_ready_o}); end
    wait_aw_hs();
    send_w(64'hA5A5_0000_1234_5678, 8'hFF, 1'b1);
    get_b(id, resp, wt);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, id} !== {64'hA5A5_0000_1234_5678, 4'h2}) begin nerr++; $display("FAIL arb_read_after_write: got data=%h id=%h, expected a5a5000012345678/2", d, id); end

    set_aw(4'h3, 64'h8000_0048, 8'd0, 2'b01, 6'd0);
    wait_aw_hs();
    send_w(64'h0BAD_F00D_0BAD_F00D, 8'hFF, 1'b1);
    get_b(id, resp, wt);

    set_aw(4'h4, 64'h8000_0048, 8'd0, 2'b01, 6'd0);
    set_ar(4'h5, 64'h8000_0048, 8'd0, 2'b01);
    #1;
    nvec++; if ({aw_ready_o, ar_ready_o} !== 2'b01) begin nerr++; $display("FAIL arb_second: got aw_ready,ar_ready=%b, expected 01", {aw_ready_o, ar_ready_o}); end
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, id} !== {64'h0BAD_F00D_0BAD_F00D, 4'h5}) begin nerr++; $display("FAIL arb_read_first: got data=%h id=%h, expected 0badf00d0badf00d/5", d, id); end
    wait_aw_hs();
    send_w(64'hC0DE_C0DE_C0DE_C0DE, 8'hFF, 1'b1);
    get_b(id, resp, wt);
    nvec++; if ({id, resp} !== {4'h4, 2'b00}) begin nerr++; $display("FAIL arb_write_second: got id=%h resp=%h, expected 4/0", id, resp); end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    logic [63:0] wdat [4];
    wdat = '{64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002, 64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004};
    set_aw(4'hC, 64'h8000_0100, 8'd3, 2'b01, 6'd0);
    wait_aw_hs();
    for (int i = 0; i < 4; i++) send_w(wdat[i], 8'hFF, i == 3);
    get_b(id, resp, wt);

    r_ready_i = 1'b0;
    set_ar(4'hD, 64'h8000_0100, 8'd3, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    r_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      nvec++;
      if ({r_valid_o, r_data_o, r_last_o, r_resp_o} !== {1'b1, wdat[1], 1'b0, 2'b00}) begin
        nerr++;
        $display("FAIL r_stall%0d: got valid=%b data=%h last=%b, expected 1/%h/0", c, r_valid_o, r_data_o, r_last_o, wdat[1]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      get_r(d, resp, last, id, wt);
      nvec++;
      if ({d, last, id} !== {wdat[i], (i == 3), 4'hD}) begin
        nerr++;
        $display("FAIL r_resume%0d: got data=%h last=%b id=%h, expected %h/%0d/d", i, d, last, id, wdat[i], (i == 3));
      end
    end
    #1;
    nvec++; if (r_valid_o !== 1'b0) begin nerr++; $display("FAIL r_no_extra: got r_valid_o=%b, expected 0", r_valid_o); end

    b_ready_i = 1'b0;
    set_aw(4'hE, 64'h8000_0030, 8'd0, 2'b01, 6'd0);
    wait_aw_hs();
    send_w(64'h6666_7777_8888_9999, 8'hFF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if ({b_valid_o, b_id_o, b_resp_o} !== {1'b1, 4'hE, 2'b00}) begin
        nerr++;
        $display("FAIL b_stall%0d: got valid=%b id=%h resp=%h, expected 1/e/0", c, b_valid_o, b_id_o, b_resp_o);
      end
      @(posedge clk_i); #1;
    end
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
    nvec++; if (b_valid_o !== 1'b0) begin nerr++; $display("FAIL b_release: got b_valid_o=%b, expected 0", b_valid_o); end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] id; logic [1:0] resp; logic last; logic [63:0] d; int wt;
    set_ar(4'h1, 64'h8000_0100, 8'd7, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    get_r(d, resp, last, id, wt);
    nvec++; if ({r_valid_o, r_data_o} !== {1'b1, 64'h3000_0000_0000_0003}) begin nerr++; $display("FAIL beat2_present: got valid=%b data=%h, expected 1/3000000000000003", r_valid_o, r_data_o); end
    rst_i = 1'b1;
    #1;
    nvec++; if (r_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_abort: got r_valid_o=%b, expected 0", r_valid_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    set_ar(4'h2, 64'h8000_0100, 8'd0, 2'b01);
    wait_ar_hs();
    get_r(d, resp, last, id, wt);
    nvec++; if ({d, resp, last, id} !== {64'h0, 2'b00, 1'b1, 4'h2}) begin nerr++; $display("FAIL post_reset_read: got data=%h resp=%h last=%b id=%h, expected 0/0/1/2", d, resp, last, id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_errors();
    test_arbitration();
    test_back_to_back_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_scratchpad_responder.md
Name: axi_scratchpad_responder

Overview:
- AXI4 responder (subordinate) fronting a flop-based scratchpad; it answers the core's AXI4+ATOP initiator port (ID 4, addr 64, data 64 bits).
- Used as a boot/scratch memory in core-level testbenches and small SoC tiles.
- Serves one transaction at a time (read or write burst). Rejects atomics and out-of-range accesses with error responses and no side effects.

Parameters:
- IdWidth, 4, AXI ID width.
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width (fixed 64; byte lanes = 8).
- NumWords, 256, scratchpad depth in 64-bit words (power of 2).
- BaseAddr, 64'h8000_0000, first byte address served; range = [BaseAddr, BaseAddr + NumWords*8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- aw_valid_i / aw_ready_o  in/out  1/1  AW handshake
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write start address
- aw_len_i  in  8  beats-1
- aw_size_i  in  3  log2 bytes per beat
- aw_burst_i  in  2  burst type
- aw_atop_i  in  6  atomic op (0 = none)
- w_valid_i / w_ready_o  in/out  1/1  W handshake
- w_data_i  in  64  write data
- w_strb_i  in  8  byte strobes
- w_last_i  in  1  last beat
- b_valid_o / b_ready_i  out/in  1/1  B handshake
- b_id_o  out  IdWidth  echoed AW ID
- b_resp_o  out  2  write response
- ar_valid_i / ar_ready_o  in/out  1/1  AR handshake
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read start address
- ar_len_i  in  8  beats-1
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  burst type
- r_valid_o / r_ready_i  out/in  1/1  R handshake
- r_id_o  out  IdWidth  echoed AR ID
- r_data_o  out  64  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last beat

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE; all *_valid_o, *_ready_o = 0; b_*/r_* payload = 0; scratchpad cleared to 0; round-robin pointer = write-first. A reset mid-burst aborts the burst with no further beats or response.
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE: aw_ready_o/ar_ready_o are driven combinationally from the arbiter. Only one is asserted.
  - If only one of aw_valid_i/ar_valid_i is set, that channel is granted.
  - If both are set, the round-robin pointer decides; the pointer flips after each grant.
  - Handshake latches ID, address, len, size, burst, and error code. AW grant -> WRITE; AR grant -> READ.
- Error code, computed at acceptance, priority order:
  - aw_atop_i != 0 -> SLVERR.
  - burst==WRAP or burst==reserved(3) -> SLVERR.
  - size > 3 -> SLVERR.
  - Any byte of the burst outside range -> DECERR. Range check uses start and end address; the end address is computed in AddrWidth+9 bits so it cannot wrap.
  - Otherwise OKAY.
- Address sequencing:
  - INCR: next address = aligned(addr, size) + (1<<size).
  - FIXED: address is held.
  - Word index = addr[3 +: log2(NumWords)] relative to BaseAddr.
  - Narrow beats use only the strobes/lanes the initiator supplies; the responder does not mask strobes by size.
- WRITE: w_ready_o=1.
  - Each W handshake with code OKAY writes the strobed bytes; with an error code, data is discarded.
  - Beat counter counts to len. On the beat with w_last_i=1 -> WRESP.
  - If w_last_i is set early or missing at the expected beat, the burst still ends on w_last_i, and resp is forced to SLVERR if the count mismatches.
- WRESP: b_valid_o=1 with latched ID and resp, held stable until b_ready_i; then -> IDLE.
  - Minimum write latency: B appears the cycle after the last W beat.
- READ: r_valid_o asserts the cycle after AR acceptance.
  - r_data_o = word at the current address, or 0 on error. r_resp_o = code. r_last_o = (beat==len).
  - Payload is held stable while r_valid_o=1 and r_ready_i=0. On handshake, advance the address.
  - After the last beat -> IDLE. Back-to-back beats are sustained at 1 per cycle.
- A write followed immediately by a read of the same word returns the new data (writes commit at the W handshake edge).
- No outstanding transactions beyond one; ready signals are low outside IDLE/WRITE as specified.

Test Plan:
- Single write/read: AW addr=0x8000_0010, len=0, size=3, data=0xDEAD_BEEF_0123_4567, strb=0xFF -> B OKAY, same ID. AR same addr -> R data=0xDEAD_BEEF_0123_4567, OKAY, last=1.
- INCR burst len=3 at 0x8000_0000 with strb=0x0F on beat 2 -> read-back returns 4 words; word 2 has only the low 4 bytes updated. R beats on 4 consecutive cycles with r_ready_i=1.
- Error paths:
  - aw_atop_i=6'h20 -> SLVERR, memory unchanged.
  - AR addr=0x7FFF_FFF8 -> DECERR, data 0.
  - AR len=1 at BaseAddr+NumWords*8-8 -> DECERR on both beats.
- Simultaneous AW and AR valid from reset -> write granted first, read second. Simultaneous again -> read granted first.
- Backpressure: hold r_ready_i=0 for 5 cycles mid-burst and b_ready_i=0 for 3 cycles -> payloads stable, no beat lost or duplicated.
- Assert rst_i during beat 2 of a len=7 read -> r_valid_o=0 immediately. After release, a fresh AR is accepted and memory reads 0.
